// File: rtl/delay_monitor.sv
`default_nettype none
// ============================================================================
// Module   : delay_monitor
// Purpose  : Locks onto a periodic single-cycle pulse (N low cycles between
//            pulses) and flags early/late pulses once locked.
// Revision : 1.0
// ============================================================================
module delay_monitor #(
    parameter int N          = 15000,
    parameter int CBITS      = 14,
    parameter int LOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    output logic       locked,
    output logic       pulse_ok,
    output logic       err_early,
    output logic       err_late,
    output logic       err_sticky,
    output logic [7:0] fault_cnt
);

    localparam logic [CBITS-1:0] C_GAP_N   = CBITS'(N);
    localparam logic [CBITS-1:0] C_GAP_MAX = '1;
    localparam logic [3:0]       C_LOCK    = 4'(LOCK_COUNT);
    localparam logic [7:0]       C_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t           r_state;
    logic [CBITS-1:0] r_gap;
    logic [3:0]       r_good;

    logic       w_hit;
    logic       w_early;
    logic       w_late;
    logic       w_fault;
    logic [3:0] w_good_inc;

    assign w_hit      = sig && (r_gap == C_GAP_N);
    assign w_early    = sig && (r_gap != C_GAP_N);
    assign w_late     = !sig && (r_gap == C_GAP_N);
    assign w_fault    = (r_state == S_TRACK) && (w_early || w_late);
    assign w_good_inc = r_good + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_gap      <= '0;
            r_good     <= 4'd0;
            locked     <= 1'b0;
            pulse_ok   <= 1'b0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
            err_sticky <= 1'b0;
            fault_cnt  <= 8'd0;
        end else begin
            pulse_ok  <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;

            // Saturate rather than wrap so a long silence in IDLE never aliases to N
            if (sig) begin
                r_gap <= '0;
            end else if (r_gap != C_GAP_MAX) begin
                r_gap <= r_gap + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (sig) begin
                        r_state <= S_ACQ;
                        r_good  <= 4'd0;
                    end
                end
                S_ACQ: begin
                    if (w_hit) begin
                        r_good   <= w_good_inc;
                        pulse_ok <= 1'b1;
                        if (w_good_inc == C_LOCK) begin
                            r_state <= S_TRACK;
                            locked  <= 1'b1;
                        end
                    end else if (w_early) begin
                        r_good <= 4'd0;
                    end else if (w_late) begin
                        r_state <= S_IDLE;
                        r_good  <= 4'd0;
                    end
                end
                S_TRACK: begin
                    if (w_hit) begin
                        pulse_ok <= 1'b1;
                    end else if (w_early) begin
                        err_early <= 1'b1;
                        r_state   <= S_ACQ;
                        r_good    <= 4'd0;
                        locked    <= 1'b0;
                    end else if (w_late) begin
                        err_late <= 1'b1;
                        r_state  <= S_IDLE;
                        r_good   <= 4'd0;
                        locked   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_good  <= 4'd0;
                    locked  <= 1'b0;
                end
            endcase

            if (w_fault) begin
                err_sticky <= 1'b1;
                if (fault_cnt != C_CNT_MAX) begin
                    fault_cnt <= fault_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_monitor
// Purpose  : Directed + randomized bench for delay_monitor against a
//            timestamp-based reference model.
// Revision : 1.0
// ============================================================================
module tb_delay_monitor;

    localparam int N          = 5;
    localparam int CBITS      = 4;
    localparam int LOCK_COUNT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sig = 1'b0;
    logic       locked;
    logic       pulse_ok;
    logic       err_early;
    logic       err_late;
    logic       err_sticky;
    logic [7:0] fault_cnt;

    int checks = 0;
    int errors = 0;

    delay_monitor #(
        .N          (N),
        .CBITS      (CBITS),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sig        (sig),
        .locked     (locked),
        .pulse_ok   (pulse_ok),
        .err_early  (err_early),
        .err_late   (err_late),
        .err_sticky (err_sticky),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: remembers the cycle of the last reference pulse and
    // judges each sample by the elapsed low-cycle count since then.
    int m_cyc = 0;
    bit m_have_ref = 0;
    int m_ref = 0;
    bit m_locked = 0;
    int m_streak = 0;
    int m_faults = 0;
    bit m_ok = 0;
    bit m_e = 0;
    bit m_l = 0;

    task automatic model_step(input logic r, input logic s);
        int d;
        m_ok = 0;
        m_e  = 0;
        m_l  = 0;
        if (!r) begin
            m_have_ref = 0;
            m_locked   = 0;
            m_streak   = 0;
            m_faults   = 0;
        end else if (!m_have_ref) begin
            if (s) begin
                m_have_ref = 1;
                m_ref      = m_cyc;
                m_streak   = 0;
            end
        end else begin
            d = m_cyc - m_ref - 1;
            if (s && d == N) begin
                m_ok = 1;
                m_streak++;
                if (m_streak >= LOCK_COUNT) m_locked = 1;
                m_ref = m_cyc;
            end else if (s) begin
                if (m_locked) begin
                    m_e = 1;
                    m_faults++;
                end
                m_locked = 0;
                m_streak = 0;
                m_ref    = m_cyc;
            end else if (d == N) begin
                if (m_locked) begin
                    m_l = 1;
                    m_faults++;
                end
                m_locked   = 0;
                m_have_ref = 0;
                m_streak   = 0;
            end
        end
        m_cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(rst, sig);
            #1;
            chk("locked",     int'(locked),     int'(m_locked));
            chk("pulse_ok",   int'(pulse_ok),   int'(m_ok));
            chk("err_early",  int'(err_early),  int'(m_e));
            chk("err_late",   int'(err_late),   int'(m_l));
            chk("err_sticky", int'(err_sticky), (m_faults > 0) ? 1 : 0);
            chk("fault_cnt",  int'(fault_cnt),  (m_faults > 255) ? 255 : m_faults);
        end
    end

    task automatic step(input logic s);
        sig = s;
        @(negedge clk);
    endtask

    task automatic pulse_after(input int lows);
        repeat (lows) step(1'b0);
        step(1'b1);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault_cnt", int'(fault_cnt), 0);
        chk("rst_sticky", int'(err_sticky), 0);
        rst = 1'b1;

        // Acquire lock
        step(1'b1);
        repeat (3) pulse_after(N);
        chk("lit_lock1", int'(locked), 1);
        chk("lit_lock1_cnt", int'(fault_cnt), 0);

        // Early pulse while locked
        pulse_after(3);
        chk("lit_early_flag", int'(err_early), 1);
        chk("lit_early_unlock", int'(locked), 0);
        chk("lit_early_cnt", int'(fault_cnt), 1);
        chk("lit_early_sticky", int'(err_sticky), 1);
        repeat (3) pulse_after(N);
        chk("lit_relock", int'(locked), 1);

        // Omitted pulse while locked
        repeat (N + 1) step(1'b0);
        chk("lit_late_flag", int'(err_late), 1);
        chk("lit_late_unlock", int'(locked), 0);
        chk("lit_late_cnt", int'(fault_cnt), 2);

        // Early pulse during acquisition restarts the count silently
        step(1'b1);
        repeat (2) pulse_after(N);
        pulse_after(2);
        chk("lit_acq_early_noerr", int'(err_early), 0);
        chk("lit_acq_early_cnt", int'(fault_cnt), 2);
        repeat (2) pulse_after(N);
        chk("lit_acq_not_locked", int'(locked), 0);
        pulse_after(N);
        chk("lit_acq_locked", int'(locked), 1);

        // Mid-track reset
        pulse_after(1);
        chk("lit_cnt3", int'(fault_cnt), 3);
        repeat (3) pulse_after(N);
        rst = 1'b0;
        step(1'b0);
        rst = 1'b1;
        chk("lit_rst_locked", int'(locked), 0);
        chk("lit_rst_cnt", int'(fault_cnt), 0);
        chk("lit_rst_sticky", int'(err_sticky), 0);
        pulse_after(N);
        chk("lit_ref_only", int'(pulse_ok), 0);
        pulse_after(N);
        chk("lit_after_ref_ok", int'(pulse_ok), 1);

        // sig held high continuously after lock
        repeat (2) pulse_after(N);
        repeat (8) step(1'b1);
        chk("lit_held_cnt", int'(fault_cnt), 1);
        chk("lit_held_unlocked", int'(locked), 0);

        // Saturation of fault counter
        for (int i = 0; i < 300; i++) begin
            repeat (3) pulse_after(N);
            if (i % 2 == 0) begin
                pulse_after($urandom_range(0, N - 1));
            end else begin
                repeat (N + 1) step(1'b0);
                step(1'b1);
            end
        end
        chk("lit_sat_cnt", int'(fault_cnt), 255);
        chk("lit_sat_sticky", int'(err_sticky), 1);

        // Randomized jittered pulse train with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                step(1'b0);
                rst = 1'b1;
            end
            if ($urandom_range(0, 9) < 7) begin
                pulse_after(N);
            end else begin
                pulse_after($urandom_range(0, N + 3));
            end
        end

        repeat (3) step(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
